// File: rtl/cc3000fpga_mss_lite.sv
// cc3000fpga_mss_lite: synthesizable stand-in for the SmartFusion MSS.
// A UART_0 command port drives an APB3 master, fabric GPOs and GPI readback.
// Also supplies the fabric clock, a delayed fabric reset, a UART_1 loopback,
// a registered GPIO pass-through and constant idle SPI_1 pins.
module cc3000fpga_mss_lite #(
  parameter int CLKS_PER_BIT = 87,
  parameter int RST_DELAY    = 16,
  parameter int APB_TIMEOUT  = 1024
) (
  input  logic        SYSCLK,
  input  logic        SYSRESET,
  input  logic        MSSPREADY,
  input  logic        MSSPSLVERR,
  input  logic [31:0] MSSPRDATA,
  input  logic        F2M_GPI_5,
  input  logic        F2M_GPI_6,
  input  logic        F2M_GPI_7,
  input  logic        F2M_GPI_8,
  input  logic        UART_0_RXD,
  input  logic        UART_1_RXD,
  input  logic        SPI_1_DI,
  input  logic        GPIO_2_IN,
  output logic        FAB_CLK,
  output logic        M2F_RESET_N,
  output logic        MSSPSEL,
  output logic        MSSPENABLE,
  output logic        MSSPWRITE,
  output logic [19:0] MSSPADDR,
  output logic [31:0] MSSPWDATA,
  output logic        M2F_GPO_0,
  output logic        M2F_GPO_1,
  output logic        M2F_GPO_3,
  output logic        M2F_GPO_9,
  output logic        M2F_GPO_11,
  output logic        M2F_GPO_12,
  output logic        M2F_GPO_13,
  output logic        UART_0_TXD,
  output logic        UART_1_TXD,
  output logic        SPI_1_DO,
  output logic        GPIO_4_OUT,
  inout  wire         SPI_1_CLK,
  inout  wire         SPI_1_SS
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int RW = $clog2(RST_DELAY + 1);
  localparam int TW = $clog2(APB_TIMEOUT + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [RW-1:0] RST_LAST  = RW'(RST_DELAY - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(APB_TIMEOUT - 1);

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_G = 8'h47;
  localparam logic [7:0] CMD_I = 8'h49;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
  typedef enum logic [2:0] {ST_IDLE, ST_ARGS, ST_SETUP, ST_ACCESS, ST_REPLY} state_t;

  // Constant and pass-through outputs; SPI_1 is parked idle and never tri-stated.
  assign FAB_CLK    = SYSCLK;
  assign UART_1_TXD = UART_1_RXD;
  assign SPI_1_DO   = 1'b0;
  assign SPI_1_CLK  = 1'b0;
  assign SPI_1_SS   = 1'b1;

  logic [RW-1:0] rst_cnt;

  // Hold the fabric in reset for RST_DELAY cycles after SYSRESET falls.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge SYSCLK or posedge SYSRESET) begin
    if (SYSRESET) begin
      rst_cnt     <= '0;
      M2F_RESET_N <= 1'b0;
    end else if (!M2F_RESET_N) begin
      rst_cnt <= rst_cnt + 1'b1;
      if (rst_cnt == RST_LAST) M2F_RESET_N <= 1'b1;
    end
  end

  // GPIO pass-through with one register of delay.
  always_ff @(posedge SYSCLK or posedge SYSRESET) begin
    if (SYSRESET) GPIO_4_OUT <= 1'b0;
    else          GPIO_4_OUT <= GPIO_2_IN;
  end

  // ---------------- UART_0 receiver ----------------
  rx_state_t     rx_state;
  logic          rx_meta, rx_sync, rx_valid;
  logic [BW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift, rx_data;

  // Synchronize RXD, qualify the start bit at half a bit, sample data mid-bit.
  // A low stop bit is a framing error: drop the byte and wait for the line to idle.
  // NOTE: synchronizer flops reset to the idle-high line level so reset release is not a start bit.
  always_ff @(posedge SYSCLK or posedge SYSRESET) begin
    if (SYSRESET) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_meta  <= UART_0_RXD;
      rx_sync  <= rx_meta;
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (!rx_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            if (rx_sync) begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
              rx_state <= RX_IDLE;
            end else rx_state <= RX_BREAK;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        default: if (rx_sync) rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- Command parser / APB master ----------------
  state_t        state;
  logic [7:0]    cmd;
  logic [2:0]    need;
  logic [47:0]   args;
  logic [TW-1:0] tmo;
  logic [39:0]   rep;
  logic [2:0]    rep_cnt;
  logic [6:0]    gpo;
  logic [9:0]    tx_frame;
  logic [3:0]    tx_bits;
  logic [BW-1:0] tx_cnt;
  logic          tx_ready, tx_take;
  logic [4:0]    unused_bits;

  assign unused_bits = {SPI_1_DI, args[47:44]};

  // The transmitter can take a byte when idle or as its stop bit ends (no gap).
  assign tx_ready = (tx_bits == 4'd0) || (tx_bits == 4'd1 && tx_cnt == BIT_LAST);
  assign tx_take  = (state == ST_REPLY) && (rep_cnt != 3'd0) && tx_ready;

  assign {M2F_GPO_13, M2F_GPO_12, M2F_GPO_11, M2F_GPO_9, M2F_GPO_3, M2F_GPO_1, M2F_GPO_0} = gpo;

  // Main FSM: decode commands, run one APB transfer, queue the reply bytes.
  always_ff @(posedge SYSCLK or posedge SYSRESET) begin
    if (SYSRESET) begin
      state      <= ST_IDLE;
      cmd        <= '0;
      need       <= '0;
      args       <= '0;
      tmo        <= '0;
      rep        <= '0;
      rep_cnt    <= '0;
      gpo        <= '0;
      MSSPSEL    <= 1'b0;
      MSSPENABLE <= 1'b0;
      MSSPWRITE  <= 1'b0;
      MSSPADDR   <= '0;
      MSSPWDATA  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (rx_valid && M2F_RESET_N) begin
          cmd <= rx_data;
          case (rx_data)
            CMD_W: begin need <= 3'd7; state <= ST_ARGS; end
            CMD_R: begin need <= 3'd3; state <= ST_ARGS; end
            CMD_G: begin need <= 3'd1; state <= ST_ARGS; end
            CMD_I: begin
              rep     <= {4'b0, F2M_GPI_8, F2M_GPI_7, F2M_GPI_6, F2M_GPI_5, 32'h0};
              rep_cnt <= 3'd1;
              state   <= ST_REPLY;
            end
            default: begin
              rep     <= {NAK, 32'h0};
              rep_cnt <= 3'd1;
              state   <= ST_REPLY;
            end
          endcase
        end
        ST_ARGS: if (rx_valid) begin
          args <= {args[39:0], rx_data};
          need <= need - 3'd1;
          if (need == 3'd1) begin
            case (cmd)
              CMD_W: begin
                MSSPADDR  <= args[43:24];
                MSSPWDATA <= {args[23:0], rx_data};
                MSSPWRITE <= 1'b1;
                MSSPSEL   <= 1'b1;
                state     <= ST_SETUP;
              end
              CMD_R: begin
                MSSPADDR  <= {args[11:0], rx_data};
                MSSPWRITE <= 1'b0;
                MSSPSEL   <= 1'b1;
                state     <= ST_SETUP;
              end
              default: begin
                gpo     <= rx_data[6:0];
                rep     <= {ACK, 32'h0};
                rep_cnt <= 3'd1;
                state   <= ST_REPLY;
              end
            endcase
          end
        end
        ST_SETUP: begin
          MSSPENABLE <= 1'b1;
          tmo        <= '0;
          state      <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (MSSPREADY || tmo == TMO_LAST) begin
            MSSPSEL    <= 1'b0;
            MSSPENABLE <= 1'b0;
            state      <= ST_REPLY;
            rep_cnt    <= 3'd1;
            if (!MSSPREADY || MSSPSLVERR) rep <= {NAK, 32'h0};
            else if (MSSPWRITE)           rep <= {ACK, 32'h0};
            else begin
              rep     <= {ACK, MSSPRDATA};
              rep_cnt <= 3'd5;
            end
          end else tmo <= tmo + 1'b1;
        end
        ST_REPLY: begin
          if (tx_take) begin
            rep     <= {rep[31:0], 8'h00};
            rep_cnt <= rep_cnt - 3'd1;
          end else if (rep_cnt == 3'd0 && tx_bits == 4'd0) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // UART_0 transmitter: 8N1 frame shifted LSB first; line rests at frame[0]=1.
  always_ff @(posedge SYSCLK or posedge SYSRESET) begin
    if (SYSRESET) begin
      tx_frame <= '1;
      tx_bits  <= '0;
      tx_cnt   <= '0;
    end else if (tx_take) begin
      tx_frame <= {1'b1, rep[39:32], 1'b0};
      tx_bits  <= 4'd10;
      tx_cnt   <= '0;
    end else if (tx_bits != 4'd0) begin
      if (tx_cnt == BIT_LAST) begin
        tx_cnt   <= '0;
        tx_frame <= {1'b1, tx_frame[9:1]};
        tx_bits  <= tx_bits - 4'd1;
      end else tx_cnt <= tx_cnt + 1'b1;
    end
  end

  assign UART_0_TXD = tx_frame[0];

endmodule

// File: tb/tb_cc3000fpga_mss_lite.sv
// Self-checking bench for cc3000fpga_mss_lite: UART command stimulus, an APB
// responder, and a reply scoreboard fed when commands are sent.
`timescale 1ns/1ps
module tb_cc3000fpga_mss_lite;

  localparam int CPB       = 87;
  localparam int RST_DELAY = 16;
  localparam int APB_TMO   = 1024;

  logic        SYSCLK = 1'b0;
  logic        SYSRESET = 1'b1;
  logic        MSSPREADY = 1'b0, MSSPSLVERR = 1'b0;
  logic [31:0] MSSPRDATA = '0;
  logic        F2M_GPI_5 = 1'b0, F2M_GPI_6 = 1'b0, F2M_GPI_7 = 1'b0, F2M_GPI_8 = 1'b0;
  logic        UART_0_RXD = 1'b1, UART_1_RXD = 1'b1, SPI_1_DI = 1'b0, GPIO_2_IN = 1'b0;
  logic        FAB_CLK, M2F_RESET_N, MSSPSEL, MSSPENABLE, MSSPWRITE;
  logic [19:0] MSSPADDR;
  logic [31:0] MSSPWDATA;
  logic        M2F_GPO_0, M2F_GPO_1, M2F_GPO_3, M2F_GPO_9, M2F_GPO_11, M2F_GPO_12, M2F_GPO_13;
  logic        UART_0_TXD, UART_1_TXD, SPI_1_DO, GPIO_4_OUT;
  wire         SPI_1_CLK, SPI_1_SS;

  always #50 SYSCLK = ~SYSCLK;

  cc3000fpga_mss_lite dut (
    .SYSCLK(SYSCLK), .SYSRESET(SYSRESET),
    .MSSPREADY(MSSPREADY), .MSSPSLVERR(MSSPSLVERR), .MSSPRDATA(MSSPRDATA),
    .F2M_GPI_5(F2M_GPI_5), .F2M_GPI_6(F2M_GPI_6), .F2M_GPI_7(F2M_GPI_7), .F2M_GPI_8(F2M_GPI_8),
    .UART_0_RXD(UART_0_RXD), .UART_1_RXD(UART_1_RXD), .SPI_1_DI(SPI_1_DI), .GPIO_2_IN(GPIO_2_IN),
    .FAB_CLK(FAB_CLK), .M2F_RESET_N(M2F_RESET_N),
    .MSSPSEL(MSSPSEL), .MSSPENABLE(MSSPENABLE), .MSSPWRITE(MSSPWRITE),
    .MSSPADDR(MSSPADDR), .MSSPWDATA(MSSPWDATA),
    .M2F_GPO_0(M2F_GPO_0), .M2F_GPO_1(M2F_GPO_1), .M2F_GPO_3(M2F_GPO_3), .M2F_GPO_9(M2F_GPO_9),
    .M2F_GPO_11(M2F_GPO_11), .M2F_GPO_12(M2F_GPO_12), .M2F_GPO_13(M2F_GPO_13),
    .UART_0_TXD(UART_0_TXD), .UART_1_TXD(UART_1_TXD), .SPI_1_DO(SPI_1_DO),
    .GPIO_4_OUT(GPIO_4_OUT), .SPI_1_CLK(SPI_1_CLK), .SPI_1_SS(SPI_1_SS)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [7:0] sb_q[$];
  int start_q[$];

  logic [6:0] gpo_vec;
  assign gpo_vec = {M2F_GPO_13, M2F_GPO_12, M2F_GPO_11, M2F_GPO_9, M2F_GPO_3, M2F_GPO_1, M2F_GPO_0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge SYSCLK) cyc <= cyc + 1;

  // APB responder and transfer monitor.
  int          ready_wait = 0;
  bit          ready_never = 1'b0;
  bit          slverr_val = 1'b0;
  logic [31:0] rdata_val = '0;
  int          setup_tot = 0, access_tot = 0, acc_n = 0;
  logic [19:0] seen_addr = '0;
  logic [31:0] seen_wdata = '0;
  logic        seen_write = 1'b0;

  always @(negedge SYSCLK) begin
    if (MSSPSEL && !MSSPENABLE) begin
      setup_tot++;
      seen_addr  = MSSPADDR;
      seen_wdata = MSSPWDATA;
      seen_write = MSSPWRITE;
    end
    if (MSSPSEL && MSSPENABLE) begin
      access_tot++;
      if (!ready_never && acc_n >= ready_wait) begin
        MSSPREADY  = 1'b1;
        MSSPSLVERR = slverr_val;
        MSSPRDATA  = rdata_val;
      end else begin
        MSSPREADY  = 1'b0;
        MSSPSLVERR = 1'b0;
        MSSPRDATA  = '0;
      end
      acc_n++;
    end else begin
      MSSPREADY  = 1'b0;
      MSSPSLVERR = 1'b0;
      MSSPRDATA  = '0;
      acc_n      = 0;
    end
  end

  // UART_0 reply decoder: pops the scoreboard for every byte it sees.
  initial begin : uart_mon
    logic [7:0] b;
    forever begin
      @(negedge SYSCLK);
      if (UART_0_TXD === 1'b0) begin
        start_q.push_back(cyc);
        repeat (CPB / 2) @(negedge SYSCLK);
        check("tx_start_bit", UART_0_TXD, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge SYSCLK);
          b[i] = UART_0_TXD;
        end
        repeat (CPB) @(negedge SYSCLK);
        check("tx_stop_bit", UART_0_TXD, 1);
        check("reply_expected", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) check("reply_byte", b, sb_q.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit good_stop = 1'b1);
    UART_0_RXD = 1'b0;
    repeat (CPB) @(negedge SYSCLK);
    for (int i = 0; i < 8; i++) begin
      UART_0_RXD = b[i];
      repeat (CPB) @(negedge SYSCLK);
    end
    UART_0_RXD = good_stop;
    repeat (CPB) @(negedge SYSCLK);
    if (!good_stop) begin
      UART_0_RXD = 1'b1;
      repeat (2 * CPB) @(negedge SYSCLK);
    end
  endtask

  // Send n bytes from the low end of 'bytes', most significant byte first.
  task automatic send_cmd(input logic [63:0] bytes, input int n);
    for (int i = n - 1; i >= 0; i--) send_byte(bytes[8*i +: 8]);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (sb_q.size() != 0 && k < budget) begin
      @(negedge SYSCLK);
      k++;
    end
    check("reply_drain_left", sb_q.size(), 0);
    repeat (2 * CPB) @(negedge SYSCLK);
  endtask

  initial begin : watchdog
    repeat (95000) @(posedge SYSCLK);
    $display("FAIL watchdog: got no finish, want finish before cycle 95000");
    $fatal(1);
  end

  initial begin : main
    int s0, a0;
    logic [3:0] gpi_pat;

    repeat (3) @(negedge SYSCLK);
    check("rst_psel", MSSPSEL, 0);
    check("rst_penable", MSSPENABLE, 0);
    check("rst_pwrite", MSSPWRITE, 0);
    check("rst_paddr", MSSPADDR, 0);
    check("rst_pwdata", MSSPWDATA, 0);
    check("rst_gpo", gpo_vec, 0);
    check("rst_txd", UART_0_TXD, 1);
    check("rst_m2f_reset_n", M2F_RESET_N, 0);
    check("rst_gpio4", GPIO_4_OUT, 0);
    check("rst_spi_clk", SPI_1_CLK, 0);
    check("rst_spi_ss", SPI_1_SS, 1);
    check("rst_spi_do", SPI_1_DO, 0);

    SYSRESET = 1'b0;
    repeat (RST_DELAY - 1) @(posedge SYSCLK);
    @(negedge SYSCLK);
    check("m2f_reset_n_early", M2F_RESET_N, 0);
    check("txd_idle_in_delay", UART_0_TXD, 1);
    @(posedge SYSCLK);
    @(negedge SYSCLK);
    check("m2f_reset_n_on_time", M2F_RESET_N, 1);
    check("spi_ss_after_rst", SPI_1_SS, 1);

    UART_1_RXD = 1'b0; #1;
    check("uart1_loop_0", UART_1_TXD, 0);
    UART_1_RXD = 1'b1; #1;
    check("uart1_loop_1", UART_1_TXD, 1);
    @(negedge SYSCLK);
    GPIO_2_IN = 1'b1; #1;
    check("gpio4_before_edge", GPIO_4_OUT, 0);
    @(posedge SYSCLK); #1;
    check("gpio4_after_edge", GPIO_4_OUT, 1);
    @(negedge SYSCLK);

    // APB write, PREADY immediately.
    ready_wait = 0;
    s0 = setup_tot; a0 = access_tot;
    sb_q.push_back(8'h06);
    send_cmd(64'h57_01_23_45_DE_AD_BE_EF, 8);
    drain(3000);
    check("w_setup_cycles", setup_tot - s0, 1);
    check("w_access_cycles", access_tot - a0, 1);
    check("w_addr", seen_addr, 20'h12345);
    check("w_wdata", seen_wdata, 32'hDEADBEEF);
    check("w_write", seen_write, 1);
    check("w_psel_idle", MSSPSEL, 0);
    check("w_addr_hold", MSSPADDR, 20'h12345);
    check("w_wdata_hold", MSSPWDATA, 32'hDEADBEEF);

    // APB read with three wait states; reply must be back to back.
    ready_wait = 3; rdata_val = 32'hCAFEF00D;
    s0 = setup_tot; a0 = access_tot;
    sb_q.push_back(8'h06); sb_q.push_back(8'hCA); sb_q.push_back(8'hFE);
    sb_q.push_back(8'hF0); sb_q.push_back(8'h0D);
    start_q.delete();
    send_cmd(64'h52_00_00_10, 4);
    drain(8000);
    check("r_setup_cycles", setup_tot - s0, 1);
    check("r_access_cycles", access_tot - a0, 4);
    check("r_addr", seen_addr, 20'h00010);
    check("r_write", seen_write, 0);
    check("r_reply_frames", start_q.size(), 5);
    if (start_q.size() == 5)
      for (int i = 1; i < 5; i++) check("r_frame_spacing", start_q[i] - start_q[i-1], 10 * CPB);

    // Read that never gets PREADY: timeout after APB_TMO access cycles, NAK only.
    ready_never = 1'b1;
    a0 = access_tot;
    sb_q.push_back(8'h15);
    send_cmd(64'h52_0A_BC_DE, 4);
    drain(6000);
    check("tmo_access_cycles", access_tot - a0, APB_TMO);
    check("tmo_addr", seen_addr, 20'hABCDE);
    check("tmo_penable", MSSPENABLE, 0);
    ready_never = 1'b0;

    // Write completing with PSLVERR; addr[23:20] must be ignored.
    ready_wait = 0; slverr_val = 1'b1;
    sb_q.push_back(8'h15);
    send_cmd(64'h57_F1_23_45_00_00_00_01, 8);
    drain(3000);
    check("err_addr", seen_addr, 20'h12345);
    check("err_wdata", seen_wdata, 32'h1);
    slverr_val = 1'b0;

    // GPO set and GPI readback.
    sb_q.push_back(8'h06);
    send_cmd(64'h47_FF, 2);
    drain(3000);
    check("gpo_all_ones", gpo_vec, 7'h7F);
    gpi_pat = 4'b1010;
    {F2M_GPI_8, F2M_GPI_7, F2M_GPI_6, F2M_GPI_5} = gpi_pat;
    sb_q.push_back({4'h0, gpi_pat});
    send_cmd(64'h49, 1);
    drain(3000);

    // Framing error inside a 'G' command must leave the parser waiting for its argument.
    sb_q.push_back(8'h06);
    send_byte(8'h47);
    send_byte(8'h57, 1'b0);
    send_byte(8'h55);
    drain(3000);
    check("gpo_after_framing", gpo_vec, 7'h55);

    // Unknown command.
    sb_q.push_back(8'h15);
    send_cmd(64'h00, 1);
    drain(3000);

    repeat (2000) @(negedge SYSCLK);
    check("end_queue_empty", sb_q.size(), 0);
    check("end_spi_clk", SPI_1_CLK, 0);
    check("end_spi_ss", SPI_1_SS, 1);
    check("end_txd_idle", UART_0_TXD, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
